// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame width.
// The transmitter imports this package as well, so the state names stay common.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DEFAULT_DATA_SIZE = 8;

    // Width of a counter covering 0..count-1, never narrower than one bit.
    function automatic int counter_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line.
// It resets to 1 so that reset never looks like a start bit.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic serial,
    output logic synced
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain[0] <= serial;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign synced = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start, DATA_SIZE data bits LSB-first, even parity, stop.
// Recovers each byte and reports parity, framing and overrun errors.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_data_in,
    input  logic                 fifo_full,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 rx_busy,
    output rx_state_t            fsm_state
);

    // Output contract: rx_valid is a one-cycle pulse with no ready/backpressure.
    // The error flags are meaningful only while rx_valid is high and are 0
    // otherwise; data_out is held from one completed frame to the next.

    localparam int TICK_W = counter_width(CLKS_PER_BIT);
    localparam int MID    = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W  = $clog2(DATA_SIZE) + 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(MID);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_SIZE - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rx_s;
    logic [TICK_W-1:0]    tick;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_SIZE-1:0] shift;
    logic                 parity_bit;
    logic                 sample;
    logic                 bit_end;
    logic                 stop_done;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .serial(serial_data_in),
        .synced(rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            // The detection cycle is tick 0. With one clock per bit it is also
            // the whole start bit, so the frame moves straight on to DATA.
            IDLE: begin
                if (!rx_s) begin
                    state_next = (CLKS_PER_BIT == 1) ? DATA : START;
                end
            end
            START: begin
                if (sample && rx_s) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == CNT_LAST)) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    state_next = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sample    = (tick == TICK_MID);
        bit_end   = (tick == TICK_LAST);
        stop_done = (state == STOP) && sample;
        rx_busy   = (state != IDLE);
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
        end else begin
            case (state)
                IDLE:         tick <= (!rx_s && CLKS_PER_BIT > 1) ? TICK_ONE : '0;
                START:        tick <= ((sample && rx_s) || bit_end) ? '0 : tick + TICK_ONE;
                DATA, PARITY: tick <= bit_end ? '0 : tick + TICK_ONE;
                STOP:         tick <= sample ? '0 : tick + TICK_ONE;
                default:      tick <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (state != DATA) begin
            bit_cnt <= '0;
        end else if (bit_end) begin
            bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // Bits arrive LSB-first: each one enters at the MSB and the word shifts right.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift      <= '0;
            parity_bit <= 1'b0;
        end else begin
            if ((state == DATA) && sample) begin
                shift <= {rx_s, shift[DATA_SIZE-1:1]};
            end
            if ((state == PARITY) && sample) begin
                parity_bit <= rx_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out      <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_valid      <= stop_done;
            parity_error  <= stop_done && (^{parity_bit, shift});
            framing_error <= stop_done && !rx_s;
            if (stop_done) begin
                data_out <= shift;
            end
        end
    end

    // The FIFO state only matters in the delivery cycle itself.
    assign overrun_error = rx_valid && fifo_full;

endmodule
